uart_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares the single UART TX byte port between NREQ sources.

---
 rtl/uart_defs_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// ---------------------------------------------------------------------------
// uart_defs
// Shared definitions for the UART TX path: byte width and the fixed source
// numbering used by the control block, the eth->uart bridge and the TX
// arbiter, so all of them agree on which arbiter port belongs to whom.
// ---------------------------------------------------------------------------
package uart_defs;

    localparam int BYTE_W   = 8;

    // Arbiter source indices.
    localparam int SRC_CTRL = 0;
    localparam int SRC_ETH  = 1;

    // Increment an index modulo n (round-robin pointer advance).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or after the pointer, wrapping modulo NREQ.
// Ports:
//   req_i  [NREQ-1:0]  request vector
//   ptr_i  [IW-1:0]    highest-priority index this cycle
//   gnt_o  [NREQ-1:0]  one-hot winner (0 if no request)
//   idx_o  [IW-1:0]    binary index of the winner (0 if no request)
//   any_o              at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int cand;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Scan NREQ positions starting at the pointer; the first hit wins.
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = IW'(cand);
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Packet-level round-robin arbiter sharing the single UART TX byte port
// between NREQ sources. A grant is held until the owner's last byte, so
// packets never interleave; a stall watchdog releases a source that stops
// sending mid-packet.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_data  [8*NREQ-1:0]    source bytes, source k at [8k+7:8k]
//   i_valid [NREQ-1:0]      source k presents a byte
//   i_last  [NREQ-1:0]      that byte ends source k's packet
//   o_ready [NREQ-1:0]      ready toward source k
//   o_data, o_valid         byte toward uart_wrapper
//   i_tx_ready              uart_wrapper can take a byte
//   o_grant [NREQ-1:0]      one-hot port owner, 0 while idle
//   o_timeout               one-cycle pulse after a forced release
//
// Handshake: a byte moves from source g to the UART in a cycle where
// o_grant[g], i_valid[g] and i_tx_ready are all high. Ready never depends on
// the source's own valid; the owner's valid and data pass straight through
// combinationally, and non-owners always see ready low.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [BYTE_W*NREQ-1:0]   i_data,
    input  logic [NREQ-1:0]          i_valid,
    input  logic [NREQ-1:0]          i_last,
    output logic [NREQ-1:0]          o_ready,
    output logic [BYTE_W-1:0]        o_data,
    output logic                     o_valid,
    input  logic                     i_tx_ready,
    output logic [NREQ-1:0]          o_grant,
    output logic                     o_timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {S_IDLE, S_LOCK} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              timeout_q, timeout_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    logic              own_valid, own_last, beat, wd_expire;
    logic [BYTE_W-1:0] own_data;
    logic [IW-1:0]     ptr_next;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (i_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign own_valid = i_valid[owner_q];
    assign own_last  = i_last[owner_q];
    assign own_data  = i_data[owner_q*BYTE_W +: BYTE_W];
    assign beat      = (state_q == S_LOCK) && own_valid && i_tx_ready;
    assign ptr_next  = IW'(wrap_inc(int'(owner_q), NREQ));

    // Watchdog counts only cycles where the owner has nothing to offer;
    // downstream backpressure with a byte waiting holds the count.
    if (TIMEOUT > 0) begin : g_wd
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (state_q != S_LOCK || beat) begin
                cnt_d = '0;
            end else if (!own_valid) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign wd_expire = (state_q == S_LOCK) && !own_valid
                           && (cnt_q == CW'(TIMEOUT - 1));
    end else begin : g_no_wd
        assign wd_expire = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        o_valid   = 1'b0;
        o_ready   = '0;
        o_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_LOCK;
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                end
            end
            S_LOCK: begin
                o_data           = own_data;
                o_valid          = own_valid;
                o_ready[owner_q] = i_tx_ready;
                // A beat excludes expiry (expiry needs valid low), so a
                // beat in the expiring cycle always wins.
                if (beat && own_last) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                end else if (wd_expire) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    ptr_d     = ptr_next;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter (NREQ=2, TIMEOUT=16): a per-cycle vector table
// for single-byte packets, non-owner and last-without-valid cases, then
// hand-written sequences for reset mid-packet, contention, fairness,
// long backpressure and watchdog release. Output bytes are checked against
// an expected queue of {source, byte}.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    import uart_defs::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_data;
    logic [1:0]  i_valid, i_last, o_ready, o_grant;
    logic [7:0]  o_data;
    logic        o_valid, i_tx_ready, o_timeout;

    always #10 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_last     (i_last),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_tx_ready (i_tx_ready),
        .o_grant    (o_grant),
        .o_timeout  (o_timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];     // {source, byte} expected on the UART side
    logic [8:0] src_q0[$];    // {last, byte} still to be offered by source 0
    logic [8:0] src_q1[$];
    int         grant_log[$];
    int         beat_cyc[$];
    int         cyc, to_cnt, to_cyc;
    bit         auto_drv;
    logic [1:0] prev_gnt;

    typedef struct packed {
        logic [1:0] v;
        logic [1:0] l;
        logic       tr;
        logic       ov;
        logic [1:0] rdy;
        logic [1:0] gnt;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic [1:0] v, logic [1:0] l, logic tr, logic ov,
                                logic [1:0] rdy, logic [1:0] gnt, logic [7:0] d);
        vec_t x;
        x.v = v; x.l = l; x.tr = tr; x.ov = ov; x.rdy = rdy; x.gnt = gnt; x.data = d;
        return x;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic qsrc(input int src, input logic [7:0] b, input bit last);
        if (src == SRC_CTRL) src_q0.push_back({last, b});
        else                 src_q1.push_back({last, b});
    endtask

    task automatic expect_byte(input int src, input logic [7:0] b);
        exp_q.push_back({src[0], b});
    endtask

    task automatic present();
        i_valid = 2'b00; i_last = 2'b00; i_data = 16'h0000;
        if (src_q0.size() > 0) begin
            i_valid[0] = 1'b1; i_last[0] = src_q0[0][8]; i_data[7:0] = src_q0[0][7:0];
        end
        if (src_q1.size() > 0) begin
            i_valid[1] = 1'b1; i_last[1] = src_q1[0][8]; i_data[15:8] = src_q1[0][7:0];
        end
    endtask

    // Called at the negedge: scoreboard compare and source-queue bookkeeping.
    task automatic monitor();
        if (o_timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (prev_gnt == 2'b00 && o_grant != 2'b00) grant_log.push_back(o_grant[1] ? 1 : 0);
        if (o_valid && i_tx_ready) begin
            beat_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: unexpected byte %0h with grant %b, nothing expected", o_data, o_grant);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("beat_src_byte", {o_grant[1], o_data}, e);
            end
        end
        if (auto_drv) begin
            if (i_valid[0] && o_ready[0] && src_q0.size() > 0) src_q0.delete(0);
            if (i_valid[1] && o_ready[1] && src_q1.size() > 0) src_q1.delete(0);
        end
        prev_gnt = o_grant;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (auto_drv) present();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        beat_cyc.delete();
        exp_q.delete();
        src_q0.delete();
        src_q1.delete();
        to_cnt   = 0;
        to_cyc   = -1;
        prev_gnt = 2'b00;
    endtask

    task automatic do_reset();
        clear_logs();
        rst = 1'b1;
        i_valid = 2'b00; i_last = 2'b00; i_data = 16'h0000;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 0);
        check("rst_grant", o_grant, 0);
        check("rst_timeout", o_timeout, 0);
        check("rst_data", o_data, 0);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL sim_timeout: simulation did not complete in time");
        $fatal(1, "time limit");
    end

    initial begin
        int n, n0, n1, alt_err, held_bad;
        rst = 1'b1; i_valid = 2'b00; i_last = 2'b00; i_data = 16'h0000;
        i_tx_ready = 1'b1; auto_drv = 1'b0; cyc = 0; prev_gnt = 2'b00;
        to_cnt = 0; to_cyc = -1;

        // v, l, tr | o_valid, o_ready, o_grant, o_data (src0=A5, src1=5A)
        tbl[0]  = mk(2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 8'h00); // idle
        tbl[1]  = mk(2'b10, 2'b10, 1, 0, 2'b00, 2'b00, 8'h00); // arbitration, no accept
        tbl[2]  = mk(2'b10, 2'b10, 1, 1, 2'b10, 2'b10, 8'h5A); // single-byte packet
        tbl[3]  = mk(2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 8'h00); // released
        tbl[4]  = mk(2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 8'h00); // ptr=0 -> src0
        tbl[5]  = mk(2'b11, 2'b00, 0, 1, 2'b00, 2'b01, 8'hA5); // backpressure, src1 ignored
        tbl[6]  = mk(2'b11, 2'b00, 1, 1, 2'b01, 2'b01, 8'hA5); // beat, not last
        tbl[7]  = mk(2'b10, 2'b01, 1, 0, 2'b01, 2'b01, 8'hA5); // last without valid
        tbl[8]  = mk(2'b01, 2'b01, 1, 1, 2'b01, 2'b01, 8'hA5); // last beat
        tbl[9]  = mk(2'b11, 2'b00, 1, 0, 2'b00, 2'b00, 8'h00); // ptr=1 -> src1
        tbl[10] = mk(2'b11, 2'b10, 1, 1, 2'b10, 2'b10, 8'h5A); // src1 single byte
        tbl[11] = mk(2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 8'h00);

        do_reset();
        #1;
        for (int r = 0; r < 12; r++) begin
            i_valid = tbl[r].v; i_last = tbl[r].l; i_tx_ready = tbl[r].tr; i_data = 16'h5AA5;
            if (tbl[r].ov && tbl[r].tr) exp_q.push_back({tbl[r].gnt[1], tbl[r].data});
            @(negedge clk);
            check($sformatf("vec%0d_valid", r), o_valid, tbl[r].ov);
            check($sformatf("vec%0d_ready", r), o_ready, tbl[r].rdy);
            check($sformatf("vec%0d_grant", r), o_grant, tbl[r].gnt);
            check($sformatf("vec%0d_data", r), o_data, tbl[r].data);
            check($sformatf("vec%0d_timeout", r), o_timeout, 0);
            monitor();
            @(posedge clk);
            #1;
        end
        check("vec_exp_empty", exp_q.size(), 0);

        // Reset in the middle of a 5-byte packet from source 0.
        auto_drv = 1'b1;
        i_tx_ready = 1'b1;
        do_reset();
        #1;
        for (int b = 0; b < 5; b++) begin
            qsrc(SRC_CTRL, 8'h10 + 8'(b), b == 4);
            expect_byte(SRC_CTRL, 8'h10 + 8'(b));
        end
        present();
        n = 0;
        while (src_q0.size() > 3 && n < 50) begin
            tick();
            n++;
        end
        check("t1_two_sent", src_q0.size(), 3);
        #2 rst = 1'b1;
        #1;
        check("t1_async_valid", o_valid, 0);
        check("t1_async_ready", o_ready, 0);
        check("t1_async_grant", o_grant, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        drain("t1", 50);
        check("t1_new_grant", grant_log.size(), 2);
        check("t1_src_empty", src_q0.size(), 0);

        // Contention: A0..A2 from src0, B0..B1 from src1, both valid at once.
        do_reset();
        #1;
        qsrc(SRC_CTRL, 8'hA0, 0); qsrc(SRC_CTRL, 8'hA1, 0); qsrc(SRC_CTRL, 8'hA2, 1);
        qsrc(SRC_ETH, 8'hB0, 0);  qsrc(SRC_ETH, 8'hB1, 1);
        expect_byte(SRC_CTRL, 8'hA0); expect_byte(SRC_CTRL, 8'hA1); expect_byte(SRC_CTRL, 8'hA2);
        expect_byte(SRC_ETH, 8'hB0);  expect_byte(SRC_ETH, 8'hB1);
        present();
        drain("t2", 50);
        check("t2_beats", beat_cyc.size(), 5);
        if (beat_cyc.size() == 5) begin
            check("t2_a_back_to_back", beat_cyc[2] - beat_cyc[0], 2);
            check("t2_gap", beat_cyc[3] - beat_cyc[2], 2);
        end
        check("t2_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t2_first_owner", grant_log[0], 0);
            check("t2_second_owner", grant_log[1], 1);
        end

        // Fairness: both sources stream single-byte packets.
        do_reset();
        #1;
        for (int i = 0; i < 10; i++) begin
            qsrc(SRC_CTRL, 8'h30 + 8'(i), 1);
            qsrc(SRC_ETH, 8'h40 + 8'(i), 1);
            expect_byte(SRC_CTRL, 8'h30 + 8'(i));
            expect_byte(SRC_ETH, 8'h40 + 8'(i));
        end
        present();
        drain("t3", 200);
        n0 = 0; n1 = 0; alt_err = 0;
        foreach (grant_log[i]) begin
            if (grant_log[i] == 0) n0++;
            else                   n1++;
            if (grant_log[i] != (i % 2)) alt_err++;
        end
        check("t3_packets", grant_log.size(), 20);
        check("t3_src0_count", n0, 10);
        check("t3_src1_count", n1, 10);
        check("t3_alternation", alt_err, 0);

        // Backpressure far longer than TIMEOUT must not trigger the watchdog.
        do_reset();
        #1;
        i_tx_ready = 1'b0;
        qsrc(SRC_CTRL, 8'hC0, 1);
        expect_byte(SRC_CTRL, 8'hC0);
        present();
        tick();
        held_bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (!(o_valid && o_grant == 2'b01 && o_data == 8'hC0 && o_ready == 2'b00)) held_bad++;
            monitor();
            @(posedge clk);
            #1;
        end
        check("t4_held", held_bad, 0);
        check("t4_no_timeout", to_cnt, 0);
        check("t4_not_sent", exp_q.size(), 1);
        i_tx_ready = 1'b1;
        drain("t4", 10);
        check("t4_no_timeout_after", to_cnt, 0);

        // Watchdog: src1 sends one byte without last, then goes quiet.
        do_reset();
        #1;
        qsrc(SRC_ETH, 8'hD0, 0);
        expect_byte(SRC_ETH, 8'hD0);
        present();
        tick();
        qsrc(SRC_CTRL, 8'hE0, 1);
        expect_byte(SRC_CTRL, 8'hE0);
        drain("t5", 60);
        check("t5_timeout_pulses", to_cnt, 1);
        check("t5_beats", beat_cyc.size(), 2);
        if (beat_cyc.size() == 2) begin
            check("t5_timeout_cycle", to_cyc - beat_cyc[0], 17);
            check("t5_src0_cycle", beat_cyc[1] - beat_cyc[0], 18);
        end
        check("t5_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t5_first_owner", grant_log[0], 1);
            check("t5_next_owner", grant_log[1], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
